// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the video RAM arbiter and
// the helpers that address the 160x120 framebuffer.
package vga_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_W        = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_H        = V_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_DEPTH    = FB_W * FB_H;
    localparam int unsigned DATA_W      = 2;
    localparam int unsigned ADDR_W      = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Pixel coordinate to framebuffer cell address; row*160 built as
// (row<<7)+(row<<5) so no multiplier is needed.
module vga_fb_addr #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [ADDR_W-1:0] cell_addr_c
);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    assign row         = ADDR_W'(pix_y >> SCALE_SHIFT);
    assign col         = ADDR_W'(pix_x >> SCALE_SHIFT);
    assign cell_addr_c = (row << 7) + (row << 5) + col;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scan-out fetches take every 4th active
// pixel slot, writes and the frame-clear engine use the remaining cycles.
module vram_arbiter #(
    parameter int unsigned DATA_W      = vga_pkg::DATA_W,
    parameter int unsigned ADDR_W      = vga_pkg::ADDR_W,
    parameter int unsigned FB_W        = vga_pkg::FB_W,
    parameter int unsigned FB_H        = vga_pkg::FB_H,
    parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              video_on,
    output logic [DATA_W-1:0] pix_color,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import vga_pkg::state_t;
    import vga_pkg::IDLE;
    import vga_pkg::WRITE;
    import vga_pkg::CLEAR;

    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] clr_col, clr_col_n;
    logic [DATA_W-1:0] cell_reg;
    logic              von_d1, von_d2;
    logic              slot_d1;
    logic              disp_slot;
    logic [ADDR_W-1:0] fetch_addr;

    vga_fb_addr #(
        .ADDR_W      (ADDR_W),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_fb_addr (
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .cell_addr_c (fetch_addr)
    );

    // Gated by rst so the combinational RAM port reads zero while in reset.
    assign disp_slot = rst & video_on & (pix_x[1:0] == 2'b00);
    assign clr_busy  = (state == CLEAR);
    assign pix_color = von_d2 ? cell_reg : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_col  <= '0;
            cell_reg <= '0;
            von_d1   <= 1'b0;
            von_d2   <= 1'b0;
            slot_d1  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            clr_col  <= clr_col_n;
            von_d1   <= video_on;
            von_d2   <= von_d1;
            slot_d1  <= disp_slot;
            if (slot_d1) begin
                cell_reg <= mem_rdata;
            end
        end
    end

    // Display slot owns the RAM port; WRITE/CLEAR only act in other cycles.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        clr_col_n = clr_col;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        wr_err    = 1'b0;

        if (disp_slot) begin
            mem_addr = fetch_addr;
        end

        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_n   = CLEAR;
                    cnt_n     = '0;
                    clr_col_n = clr_color;
                end else if (wr_req) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (!disp_slot) begin
                    wr_ack  = 1'b1;
                    state_n = IDLE;
                    if (wr_addr < ADDR_W'(FB_DEPTH)) begin
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end else begin
                        wr_err = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (!disp_slot) begin
                    mem_we    = 1'b1;
                    mem_addr  = cnt;
                    mem_wdata = clr_col;
                    cnt_n     = cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(FB_DEPTH - 1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
